// File: rtl/sfp_out_packer.sv
// Output packer: per-lane ReLU / round-shift / saturate, lane packing, and a
// show-ahead FIFO drained over valid/ready. One stage register precedes the FIFO.

module sfp_lane_quant #(
  parameter int psum_bw = 16,
  parameter int bw      = 4
) (
  input  logic [psum_bw-1:0] i_x,
  input  logic               i_relu,
  input  logic [3:0]         i_shift,
  output logic [bw-1:0]      o_q
);
  localparam logic signed [psum_bw:0] P_UMAX = (psum_bw+1)'((2**bw) - 1);
  localparam logic signed [psum_bw:0] P_SMAX = (psum_bw+1)'((2**(bw-1)) - 1);
  localparam logic signed [psum_bw:0] P_SMIN = ~P_SMAX;

  logic [psum_bw-1:0]        w_xr;
  logic signed [psum_bw:0]   w_ext;
  logic signed [psum_bw:0]   w_bias;
  logic signed [psum_bw:0]   w_sum;
  logic signed [psum_bw:0]   w_y;

  always_comb begin
    w_xr   = (i_relu && i_x[psum_bw-1]) ? '0 : i_x;
    w_ext  = {w_xr[psum_bw-1], w_xr};
    w_bias = '0;
    w_sum  = w_ext;
    w_y    = w_ext;
    if (i_shift != 4'd0) begin
      // one extra bit keeps the rounding add from wrapping
      w_bias = (psum_bw+1)'(1) << (i_shift - 4'd1);
      w_sum  = w_ext + w_bias;
      w_y    = w_sum >>> i_shift;
    end
    o_q = w_y[bw-1:0];
    if (i_relu) begin
      if (w_y > P_UMAX) o_q = P_UMAX[bw-1:0];
    end else begin
      if (w_y > P_SMAX)      o_q = P_SMAX[bw-1:0];
      else if (w_y < P_SMIN) o_q = P_SMIN[bw-1:0];
    end
  end
endmodule

module sfp_out_packer #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int bw      = 4,
  parameter int depth   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_in_valid,
  input  logic [psum_bw*col-1:0]     i_in_data,
  output logic                       o_in_ready,
  input  logic                       i_cfg_relu,
  input  logic [3:0]                 i_cfg_shift,
  input  logic                       i_clear,
  output logic                       o_out_valid,
  output logic [bw*col-1:0]          o_out_data,
  input  logic                       i_out_ready,
  output logic [$clog2(depth):0]     o_count,
  output logic                       o_overflow
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [bw*col-1:0] w_q;
  logic [bw*col-1:0] r_stg;
  logic              r_stg_vld;
  logic [bw*col-1:0] r_mem [depth];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic [CW-1:0]     w_fifo_cnt;
  logic              w_acc;
  logic              w_pop;

  for (genvar g = 0; g < col; g++) begin : gen_lane
    sfp_lane_quant #(.psum_bw(psum_bw), .bw(bw)) u_lane (
      .i_x     (i_in_data[psum_bw*g +: psum_bw]),
      .i_relu  (i_cfg_relu),
      .i_shift (i_cfg_shift),
      .o_q     (w_q[bw*g +: bw])
    );
  end

  // count includes the stage word, so the FIFO itself holds count - stage
  assign w_fifo_cnt  = r_count - CW'(r_stg_vld);
  assign o_in_ready  = (r_count < CW'(depth));
  assign o_out_valid = (w_fifo_cnt != '0);
  assign o_out_data  = o_out_valid ? r_mem[r_rd] : '0;
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign w_acc       = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      r_stg     <= '0;
      r_stg_vld <= 1'b0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_stg_vld <= w_acc;
      if (w_acc)     r_stg <= w_q;
      if (r_stg_vld) r_wr  <= r_wr + AW'(1);
      if (w_pop)     r_rd  <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_acc) - CW'(w_pop);
      if (i_in_valid && !o_in_ready) r_ovf <= 1'b1;
    end
  end

  // storage needs no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge i_clk) begin
    if (r_stg_vld) r_mem[r_wr] <= r_stg;
  end
endmodule

// File: tb/tb_sfp_out_packer.sv
// Directed bench for sfp_out_packer with a scoreboard queue of expected packed words.

module tb_sfp_out_packer;
  localparam int COL = 8, PBW = 16, BW = 4, DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_in_valid = 1'b0;
  logic [PBW*COL-1:0]   i_in_data = '0;
  logic                 o_in_ready;
  logic                 i_cfg_relu = 1'b0;
  logic [3:0]           i_cfg_shift = 4'd0;
  logic                 i_clear = 1'b0;
  logic                 o_out_valid;
  logic [BW*COL-1:0]    o_out_data;
  logic                 i_out_ready = 1'b0;
  logic [4:0]           o_count;
  logic                 o_overflow;

  int checks = 0;
  int errors = 0;
  logic [BW*COL-1:0] q[$];

  sfp_out_packer #(.col(COL), .psum_bw(PBW), .bw(BW), .depth(DEPTH)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
    .o_in_ready(o_in_ready), .i_cfg_relu(i_cfg_relu), .i_cfg_shift(i_cfg_shift),
    .i_clear(i_clear), .o_out_valid(o_out_valid), .o_out_data(o_out_data),
    .i_out_ready(i_out_ready), .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW*COL-1:0] model(input logic [PBW*COL-1:0] d, input bit relu,
                                              input int sh);
    logic [BW*COL-1:0] r;
    int x, y, p, t;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      x = int'($signed(d[PBW*i +: PBW]));
      if (relu && x < 0) x = 0;
      if (sh > 0) begin
        p = 1 << sh;
        t = x + p / 2;
        y = (t >= 0) ? t / p : -((-t + p - 1) / p);
      end else y = x;
      if (relu) begin
        if (y > 15) y = 15;
      end else begin
        if (y > 7) y = 7;
        else if (y < -8) y = -8;
      end
      r[BW*i +: BW] = y[3:0];
    end
    return r;
  endfunction

  function automatic logic [PBW*COL-1:0] rand_word();
    logic [PBW*COL-1:0] d;
    for (int i = 0; i < COL; i++) d[PBW*i +: PBW] = 16'($urandom_range(0, 511)) - 16'd256;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [PBW*COL-1:0] d, input bit relu, input logic [3:0] sh,
                        input bit exp_acc);
    i_in_valid  = 1'b1;
    i_in_data   = d;
    i_cfg_relu  = relu;
    i_cfg_shift = sh;
    chk("in_ready_at_strobe", {31'd0, o_in_ready}, {31'd0, exp_acc});
    if (exp_acc) q.push_back(model(d, relu, int'(sh)));
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    i_out_ready = 1'b1;
    while (o_count != 5'd0 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_drain_count"}, {27'd0, o_count}, 32'd0);
    chk({tag, "_sb_empty"}, q.size(), 32'd0);
    i_out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (o_out_valid && i_out_ready) begin
      chk("sb_has_entry", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) chk("pop_data", o_out_data, q.pop_front());
    end
  end

  logic [PBW*COL-1:0] wa, wb;

  initial begin
    wa = {16'd7, 16'd6, 16'd5, 16'd4, 16'd0, -16'sd9, 16'd100, 16'd19};
    wb = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, -16'sd100, 16'd100, -16'sd9};

    // reset, then idle
    repeat (3) step();
    i_reset = 1'b1;
    step();
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_count", {27'd0, o_count}, 32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_out_data", o_out_data, 32'd0);

    // ReLU, shift 2
    i_out_ready = 1'b1;
    strobe(wa, 1'b1, 4'd2, 1'b1);
    chk("a_count_stage", {27'd0, o_count}, 32'd1);
    chk("a_valid_early", {31'd0, o_out_valid}, 32'd0);
    step();
    chk("a_valid", {31'd0, o_out_valid}, 32'd1);
    chk("a_data", o_out_data, 32'h221100F5);
    step();
    chk("a_count_after", {27'd0, o_count}, 32'd0);
    chk("a_valid_after", {31'd0, o_out_valid}, 32'd0);

    // signed, shift 1
    strobe(wb, 1'b0, 4'd1, 1'b1);
    step();
    chk("b_valid", {31'd0, o_out_valid}, 32'd1);
    chk("b_data", o_out_data, 32'h0000087C);
    step();
    chk("b_count_after", {27'd0, o_count}, 32'd0);

    // 17 back-to-back strobes into a stalled consumer
    i_out_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      strobe(rand_word(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), i < 16);
    chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
    chk("ovf_count", {27'd0, o_count}, 32'd16);
    step();
    chk("ovf_count_hold", {27'd0, o_count}, 32'd16);
    chk("ovf_in_ready", {31'd0, o_in_ready}, 32'd0);
    drain("ovf");
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clr_overflow", {31'd0, o_overflow}, 32'd0);

    // full FIFO, strobe together with pop
    for (int i = 0; i < 16; i++) strobe(rand_word(), 1'b0, 4'($urandom_range(0, 15)), 1'b1);
    step();
    chk("full_count", {27'd0, o_count}, 32'd16);
    i_out_ready = 1'b1;
    strobe(rand_word(), 1'b1, 4'd3, 1'b0);
    i_out_ready = 1'b0;
    chk("full_pop_count", {27'd0, o_count}, 32'd15);
    chk("full_pop_ovf", {31'd0, o_overflow}, 32'd1);
    drain("full");
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;

    // clear with a simultaneous strobe
    for (int i = 0; i < 10; i++) strobe(rand_word(), 1'b1, 4'd1, 1'b1);
    step();
    chk("buf10_count", {27'd0, o_count}, 32'd10);
    i_clear = 1'b1;
    i_in_valid = 1'b1;
    i_in_data = rand_word();
    step();
    i_clear = 1'b0;
    i_in_valid = 1'b0;
    q.delete();
    chk("clr_count", {27'd0, o_count}, 32'd0);
    chk("clr_valid", {31'd0, o_out_valid}, 32'd0);
    chk("clr_ovf", {31'd0, o_overflow}, 32'd0);
    chk("clr_data", o_out_data, 32'd0);
    chk("clr_in_ready", {31'd0, o_in_ready}, 32'd1);
    step();
    chk("clr_no_accept", {27'd0, o_count}, 32'd0);
    chk("clr_no_valid", {31'd0, o_out_valid}, 32'd0);

    // reset mid-drain
    for (int i = 0; i < 10; i++) strobe(rand_word(), 1'b0, 4'd2, 1'b1);
    step();
    i_out_ready = 1'b1;
    repeat (3) step();
    chk("mid_count", {27'd0, o_count}, 32'd7);
    i_reset = 1'b0;
    i_in_valid = 1'b1;
    step();
    i_reset = 1'b1;
    i_in_valid = 1'b0;
    q.delete();
    chk("mrst_count", {27'd0, o_count}, 32'd0);
    chk("mrst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("mrst_ovf", {31'd0, o_overflow}, 32'd0);
    step();
    chk("mrst_no_accept", {27'd0, o_count}, 32'd0);

    // datapath still correct after the mid-drain reset
    strobe(wb, 1'b0, 4'd1, 1'b1);
    step();
    chk("post_data", o_out_data, 32'h0000087C);
    step();
    chk("post_count", {27'd0, o_count}, 32'd0);
    chk("post_sb_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
